// File: rtl/seq_frame_serializer_if.sv
// rtl/seq_frame_serializer_if.sv - payload valid/ready handshake into the frame serializer
interface seq_frame_serializer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/seq_frame_serializer.sv
// rtl/seq_frame_serializer.sv - preamble + MSB-first payload + idle gap serializer
// Optional trailing even-parity bit when SEQ_FRAME_PARITY_EN is defined.
module seq_frame_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter logic [7:0]  PREAMBLE   = 8'b0000_1010,
  parameter int unsigned PRE_LEN    = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_frame_serializer_if.slave  in_if,
  output logic                   x_out_o,
  output logic                   x_valid_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int unsigned MAX_PD  = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int unsigned CNT_MAX = (MAX_PD > GAP_CYCLES) ? MAX_PD : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // Preamble left-justified so bit 7 is always the next bit to send.
  localparam logic [7:0]       PRE_ALIGNED = PREAMBLE << (8 - PRE_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PAY,
`ifdef SEQ_FRAME_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [7:0]        pre_q, pre_d;
  logic              x_out_q, x_out_d;
  logic              x_valid_q, x_valid_d;
  logic              frame_done_q, frame_done_d;
`ifdef SEQ_FRAME_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    pre_d     = pre_q;
    x_out_d   = 1'b0;
    x_valid_d = 1'b0;
`ifdef SEQ_FRAME_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_if.data_valid) begin
          state_d   = S_PRE;
          cnt_d     = '0;
          shift_d   = in_if.data_in;
          pre_d     = PRE_ALIGNED << 1;
          x_out_d   = PRE_ALIGNED[7];
          x_valid_d = 1'b1;
`ifdef SEQ_FRAME_PARITY_EN
          par_d     = ^in_if.data_in;
`endif
        end
      end
      S_PRE: begin
        x_valid_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = S_PAY;
          cnt_d   = '0;
          x_out_d = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          x_out_d = pre_q[7];
          pre_d   = pre_q << 1;
        end
      end
      S_PAY: begin
        if (cnt_q == PAY_LAST) begin
          cnt_d = '0;
`ifdef SEQ_FRAME_PARITY_EN
          state_d   = S_PAR;
          x_out_d   = par_q;
          x_valid_d = 1'b1;
`else
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
`endif
        end else begin
          cnt_d     = cnt_q + 1'b1;
          x_valid_d = 1'b1;
          x_out_d   = shift_q[DATA_W-1];
          shift_d   = shift_q << 1;
        end
      end
`ifdef SEQ_FRAME_PARITY_EN
      S_PAR: begin
        cnt_d   = '0;
        state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
`endif
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // frame_done is registered, so it is decided from the bit about to be shown.
`ifdef SEQ_FRAME_PARITY_EN
    frame_done_d = (state_d == S_PAR);
`else
    frame_done_d = (state_d == S_PAY) && (cnt_d == PAY_LAST);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      pre_q        <= '0;
      x_out_q      <= 1'b0;
      x_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SEQ_FRAME_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      pre_q        <= pre_d;
      x_out_q      <= x_out_d;
      x_valid_q    <= x_valid_d;
      frame_done_q <= frame_done_d;
`ifdef SEQ_FRAME_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign in_if.data_ready = (state_q == S_IDLE);
  assign busy_o           = (state_q != S_IDLE);
  assign x_out_o          = x_out_q;
  assign x_valid_o        = x_valid_q;
  assign frame_done_o     = frame_done_q;

endmodule

// File: tb/tb_seq_frame_serializer.sv
// tb/tb_seq_frame_serializer.sv - directed bench for seq_frame_serializer
// Expectations adapt when SEQ_FRAME_PARITY_EN is defined.
module tb_seq_frame_serializer;
`ifdef SEQ_FRAME_PARITY_EN
  localparam int FL = 13;
`else
  localparam int FL = 12;
`endif
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x_out, x_valid, busy, frame_done;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_frame_serializer_if #(.DATA_W(8)) in_if ();

  seq_frame_serializer #(
    .DATA_W(8), .PREAMBLE(8'b0000_1010), .PRE_LEN(4), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_if(in_if),
    .x_out_o(x_out), .x_valid_o(x_valid), .busy_o(busy), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {x_valid, x_out, frame_done, busy, data_ready}
  function automatic logic [4:0] st();
    return {x_valid, x_out, frame_done, busy, in_if.data_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] frame_model(input logic [7:0] d);
`ifdef SEQ_FRAME_PARITY_EN
    return {3'b000, 4'b1010, d, ^d};
`else
    return {4'b0000, 4'b1010, d};
`endif
  endfunction

  // Sends one word, checks every frame/gap cycle, returns the serial bits and
  // where an overlapping 1010 detector on the line would fire.
  task automatic run_frame(input logic [7:0] d, input string tag,
                           output logic [15:0] bits, output logic [15:0] zmask);
    logic [15:0] fm;
    logic [3:0]  hist;
    fm    = frame_model(d);
    bits  = '0;
    zmask = '0;
    hist  = '0;
    check({tag, " idle before"}, st(), 5'b00001);
    in_if.data_in    = d;
    in_if.data_valid = 1'b1;
    step();
    in_if.data_valid = 1'b0;
    in_if.data_in    = 'x;
    for (int i = 0; i < FL; i++) begin
      check({tag, " frame bit"}, st(), {1'b1, fm[FL-1-i], (i == FL-1), 1'b1, 1'b0});
      bits = {bits[14:0], x_out};
      if (x_valid) hist = {hist[2:0], x_out};
      if (hist == 4'b1010) zmask[i] = 1'b1;
      step();
    end
    for (int g = 0; g < GAP; g++) begin
      check({tag, " gap"}, st(), 5'b00010);
      step();
    end
    check({tag, " idle after"}, st(), 5'b00001);
  endtask

  logic [15:0] bits, zmask;
  logic [15:0] fb [2];
  int          rise [2];
  int          nr, acc;
  logic        prev_v;

  initial begin
    in_if.data_valid = 1'b0;
    in_if.data_in    = '0;
    step();
    step();
    check("reset state", st(), 5'b00001);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle no valid", st(), 5'b00001);
    end

    run_frame(8'hA5, "a5", bits, zmask);
`ifdef SEQ_FRAME_PARITY_EN
    check("a5 serial bits", bits, 16'h154A);
`else
    check("a5 serial bits", bits, 16'h0AA5);
`endif

    // data_valid held high across two words
    nr = 0; acc = 0; prev_v = 1'b0;
    fb[0] = '0; fb[1] = '0; rise[0] = 0; rise[1] = 0;
    for (int c = 0; c < 40; c++) begin
      if (in_if.data_ready) begin
        if (acc < 2) begin
          in_if.data_in    = (acc == 0) ? 8'hFF : 8'h00;
          in_if.data_valid = 1'b1;
          acc++;
        end else begin
          in_if.data_valid = 1'b0;
        end
      end
      step();
      if (x_valid && !prev_v && nr < 2) begin
        rise[nr] = c;
        nr++;
      end
      if (x_valid && nr > 0) fb[nr-1] = {fb[nr-1][14:0], x_out};
      prev_v = x_valid;
    end
    check("b2b frame count", nr, 2);
    check("b2b preamble spacing", rise[1] - rise[0], FL + GAP + 1);
`ifdef SEQ_FRAME_PARITY_EN
    check("b2b first frame", fb[0], 16'h15FE);
    check("b2b second frame", fb[1], 16'h1400);
`else
    check("b2b first frame", fb[0], 16'h0AFF);
    check("b2b second frame", fb[1], 16'h0A00);
`endif
    check("b2b idle after", st(), 5'b00001);

    // reset on the 3rd payload bit of 8'h3C
    in_if.data_in    = 8'h3C;
    in_if.data_valid = 1'b1;
    step();
    in_if.data_valid = 1'b0;
    repeat (6) step();
    check("3c third payload bit", st(), 5'b11010);
    rst_n = 1'b0;
    #1;
    check("mid-frame reset", st(), 5'b00001);
    for (int c = 0; c < 3; c++) begin
      step();
      check("held in reset", st(), 5'b00001);
    end
    rst_n = 1'b1;
    step();
    run_frame(8'h81, "81", bits, zmask);
`ifdef SEQ_FRAME_PARITY_EN
    check("81 after reset", bits, 16'h1502);
`else
    check("81 after reset", bits, 16'h0A81);
`endif

    run_frame(8'h0A, "0a", bits, zmask);
    check("0a detector hits", zmask, 16'h0808);

    run_frame(8'h07, "07", bits, zmask);
`ifdef SEQ_FRAME_PARITY_EN
    check("07 serial bits", bits, 16'h140F);
    check("07 parity bit", bits[0], 1'b1);
`else
    check("07 serial bits", bits, 16'h0A07);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_frame_serializer.md
Name: seq_frame_serializer

Overview:
- Transmit-side counterpart to the team's serial sequence detectors.
- Accepts a parallel payload word over a valid/ready handshake.
- Serializes it MSB-first on a single-bit line, preceded by a fixed sync preamble (default 1010) and followed by an idle gap.
- Drives the `x` input of a downstream overlapping 1010 detector and feeds framed serial links in the test fabric.

Parameters:
- DATA_W, 8: payload width in bits; legal range 1..32.
- PREAMBLE, 4'b1010: sync pattern, sent MSB-first.
- PRE_LEN, 4: number of preamble bits; legal range 1..8. Only the PRE_LEN LSBs of PREAMBLE are used.
- GAP_CYCLES, 1: idle cycles after each frame; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_in  input  DATA_W  payload word to transmit.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block can accept a word.
- x_out  output  1  serial bit, registered.
- x_valid  output  1  x_out carries a frame bit this cycle, registered.
- busy  output  1  frame in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse on the last bit of a frame.

Behaviour:
- Reset values (async assert, held while rst_n=0): x_out=0, x_valid=0, busy=0, frame_done=0, data_ready=1, state=IDLE, counters=0, shift register=0.
- data_ready = (state==IDLE). Accept occurs on a rising edge where data_valid && data_ready. data_in is captured into the shift register on that edge. data_in is ignored while data_ready=0; the source must hold it.
- FSM states: IDLE, PRE, PAY, GAP, plus PAR when the optional feature is enabled.
  - IDLE: on accept -> PRE. The first preamble bit appears on x_out in the cycle after the accept edge (1-cycle latency). Otherwise stay in IDLE with x_out=0, x_valid=0.
  - PRE: x_out = PREAMBLE[PRE_LEN-1-k] for k=0..PRE_LEN-1; x_valid=1. After PRE_LEN cycles -> PAY.
  - PAY: x_out = shift register MSB; shift left by 1 each cycle, filling with 0; x_valid=1. After DATA_W cycles -> GAP, or -> IDLE when GAP_CYCLES=0.
  - GAP: x_out=0, x_valid=0, busy=1 for GAP_CYCLES cycles, then -> IDLE.
- frame_done=1 exactly during the cycle the final frame bit is on x_out (last payload bit, or parity bit when enabled).
- Frame period: PRE_LEN + DATA_W + GAP_CYCLES + 1 cycles (the +1 is the IDLE accept cycle). No back-to-back acceptance while busy.
- Bit counter is sized for max(PRE_LEN, DATA_W, GAP_CYCLES). It resets to 0 on every state change; no wrap-around within a state.
- data_valid held high continuously: the next word is accepted on the first IDLE cycle after the gap.
- Reset mid-frame: frame aborted immediately; outputs return to reset values; no frame_done; the partial word is discarded.
- X/Z on data_in while data_valid=0 has no effect on outputs.

Optional Feature:
- Macro: SEQ_FRAME_PARITY_EN
- Defined:
  - State PAR is inserted between PAY and GAP/IDLE for 1 cycle.
  - x_out = even parity (XOR) of the captured payload; x_valid=1.
  - frame_done moves to the PAR cycle.
  - Frame period grows by 1.
  - Parity is computed at the accept edge and stored.
- Not defined: no PAR state, no parity logic; frame format as above.

Test Plan:
- Reset release, data_valid=0 for 10 cycles -> data_ready=1, x_valid=0, x_out=0, busy=0 throughout.
- DATA_W=8, data_in=8'hA5 pulsed for 1 cycle -> from the next cycle x_out = 1,0,1,0 then 1,0,1,0,0,1,0,1 with x_valid=1 for 12 cycles; frame_done on cycle 12; then 1 gap cycle with x_valid=0; data_ready returns high on cycle 14.
- data_valid held high with words 8'hFF then 8'h00 -> two frames; second preamble starts exactly 14 cycles after the first; second payload is all zeros.
- rst_n asserted on the 3rd payload bit of 8'h3C -> outputs return to reset values immediately; no frame_done; after release, a new word 8'h81 transmits a clean full frame.
- Loopback into the overlapping 1010 detector, data_in=8'h0A -> detector z pulses on the 4th preamble bit and on the last payload bit (bits ...1010).
- SEQ_FRAME_PARITY_EN defined, data_in=8'h07 -> 13th frame bit x_out=1 (three ones, odd count, so the even-parity bit is 1); frame_done on that bit; gap follows.
